nes_gamepad_reader: RTL and testbench
=====================================

# nes_gamepad_reader

Polls an NES-style serial gamepad (latch/clock/data shift-register protocol) and presents the eight buttons as registered, active-high levels for the player logic. It sits between the board's controller pins and the `player` block, driving that block's `A`, `B`, `select`, `start`, `up`, `down`, `left` and `right` inputs. Opposing directions pressed together are cancelled before they reach the player logic. A one-cycle `valid` strobe marks each completed poll.

## Interface
- `HALF_PERIOD`, default 150: `clk` cycles per half bit-period (6 µs at 25 MHz). Must be ≥ 1.
- `POLL_CYCLES`, default 416667: `clk` cycles between frame starts (60 Hz at 25 MHz). Must be > 16·HALF_PERIOD.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `pad_data`  in  1  serial data from the pad; active-low (0 = pressed).
- `pad_latch`  out  1  latch strobe to the pad; active-high.
- `pad_clk`  out  1  shift clock to the pad; idles low.
- `A`, `B`, `select`, `start`, `up`, `down`, `left`, `right`  out  1 each  registered button levels; active-high.
- `valid`  out  1  one-cycle pulse on the cycle the button outputs update.

## Operation
- Bit order on `pad_data`: 0 = A, 1 = B, 2 = select, 3 = start, 4 = up, 5 = down, 6 = left, 7 = right.
- The sampled bit is inverted into an 8-bit shift register.
- States: IDLE, LATCH, CLK_HIGH, CLK_LOW, DONE.
- IDLE: outputs held. Go to LATCH when the poll timer reaches POLL_CYCLES−1.
- LATCH: `pad_latch`=1 for 2·H cycles. Sample bit 0 on the last of those cycles.
- CLK_HIGH: `pad_clk`=1 for H cycles.
- CLK_LOW: `pad_clk`=0 for H cycles. Sample the next bit on the last cycle.
- After bit 7 is sampled, go to DONE. Otherwise return to CLK_HIGH.
- Seven CLK_HIGH/CLK_LOW pairs run per frame.
- DONE (one cycle): load the button outputs from the shift register, assert `valid`, go to IDLE.
- Opposing-direction filter, applied at load:
  - If up and down are both pressed, both outputs are 0.
  - If left and right are both pressed, both outputs are 0.
  - A, B, select and start are never filtered.
- Disconnected pad (`pad_data` stuck high): every button reads 0. `valid` still pulses. There is no error flag.
- Poll timer:
  - Free-running, width $clog2(POLL_CYCLES).
  - Wraps at POLL_CYCLES−1.
  - Cleared by reset.
  - Frame starts depend only on the timer, never on frame completion.

## Timing
H = HALF_PERIOD. Cycle 0 is the first cycle with `reset` low.
- Reset values: all button outputs 0, `valid` 0, `pad_latch` 0, `pad_clk` 0, state IDLE.
- After reset, the first frame starts immediately: LATCH occupies cycles 0 … 2H−1.
- Bit 0 is sampled at cycle 2H−1.
- For bit k (k = 1 … 7):
  - `pad_clk` is high over cycles 2Hk … 2Hk+H−1.
  - `pad_clk` is low over cycles 2Hk+H … 2Hk+2H−1.
  - Bit k is sampled at cycle 2Hk+2H−1.
- Bit 7 is sampled at cycle 16H−1.
- Button outputs and `valid` change at cycle 16H. `valid` is high for exactly that cycle.
- Later frames start at cycles n·POLL_CYCLES.
- `pad_latch` and `pad_clk` are registered, with no glitches, and are never high together.
- Reset asserted mid-frame:
  - The frame is aborted and the partial shift register discarded.
  - No `valid` pulse is produced.
  - Outputs take reset values on the next edge.
- Button outputs are stable between `valid` pulses.

## Structure
- Shared package `gamepad_pkg`:
  - Button index constants BTN_A … BTN_RIGHT (0–7).
  - State encoding for the five states.
- One sub-module, `pad_bit_timer`:
  - Counts H-cycle phases.
  - Provides `phase_end`, asserted on the last cycle of each half bit-period.
  - Provides a bit-index counter, 0–7.
- FSM, shift register, direction filter and poll timer live in the top module.

## Test plan
Bench parameters: HALF_PERIOD=2, POLL_CYCLES=64. The pad model shifts on the rising edge of `pad_clk`.
- Reset held 3 cycles → all outputs 0, `pad_latch`=`pad_clk`=0. After release, `pad_latch`=1 on cycles 0–3.
- Pad reports A only (bit 0 low) → at cycle 32, A=1, all others 0, `valid`=1 for one cycle.
- Pad reports up+down+left (bits 4, 5, 6 low) → at cycle 32, up=0, down=0, left=1.
- Pad reports right+start (bits 7, 3 low) → right=1, start=1. Outputs hold until the second `valid` at cycle 96, which reflects a new pattern.
- Reset pulsed at cycle 10 mid-frame → no `valid` at cycle 32. Frame restarts at the release cycle. `valid` arrives 32 cycles after release.
- `pad_data` held high for two frames → all buttons 0. `valid` pulses at cycles 32 and 96.

Source files
------------

// File: rtl/gamepad_pkg.sv
// Shared definitions for the NES gamepad reader: button bit positions, FSM
// state encoding and the opposing-direction filter applied when buttons load.
package gamepad_pkg;

  localparam int unsigned NUM_BUTTONS = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_CLK_HIGH = 3'd2,
    ST_CLK_LOW  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Opposing directions held together cancel each other; face buttons pass.
  function automatic logic [NUM_BUTTONS-1:0] filter_dirs(input logic [NUM_BUTTONS-1:0] raw);
    logic [NUM_BUTTONS-1:0] filt;
    filt = raw;
    if (raw[BTN_UP] && raw[BTN_DOWN]) begin
      filt[BTN_UP]   = 1'b0;
      filt[BTN_DOWN] = 1'b0;
    end
    if (raw[BTN_LEFT] && raw[BTN_RIGHT]) begin
      filt[BTN_LEFT]  = 1'b0;
      filt[BTN_RIGHT] = 1'b0;
    end
    return filt;
  endfunction

endpackage

// File: rtl/pad_bit_timer.sv
// Half bit-period timer: counts H-cycle phases in pairs and tracks which of the
// eight pad bits is in flight. Held cleared whenever run_i is low.
module pad_bit_timer #(
  parameter int unsigned HALF_PERIOD = 150
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_i,
  output logic       phase_end_o,
  output logic       bit_end_o,
  output logic [2:0] bit_idx_o
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;
  logic [2:0]    bit_q, bit_d;

  assign phase_end_o = run_i && (cnt_q == CNT_LAST);
  // A bit period ends on the second of its two phases.
  assign bit_end_o   = phase_end_o && half_q;
  assign bit_idx_o   = bit_q;

  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    bit_d  = bit_q;
    if (!run_i) begin
      cnt_d  = '0;
      half_d = 1'b0;
      bit_d  = '0;
    end else if (phase_end_o) begin
      cnt_d  = '0;
      half_d = ~half_q;
      if (half_q) begin
        bit_d = bit_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
      bit_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/nes_gamepad_reader.sv
// Polls an NES serial gamepad once per POLL_CYCLES and presents the eight
// buttons as registered active-high levels with a one-cycle valid strobe.
module nes_gamepad_reader
  import gamepad_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 150,
  parameter int unsigned POLL_CYCLES = 416667
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic A,
  output logic B,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic valid
);

  localparam int unsigned TW = $clog2(POLL_CYCLES);
  localparam logic [TW-1:0] POLL_LAST = TW'(POLL_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [TW-1:0]            poll_q, poll_d;
  logic [NUM_BUTTONS-1:0]   shift_q, shift_d;
  logic [NUM_BUTTONS-1:0]   btn_q, btn_d;
  logic                     valid_q, valid_d;
  logic                     latch_q, pclk_q;
  logic                     timer_run;
  logic                     phase_end;
  logic                     bit_end;
  logic [2:0]               bit_idx;

  assign timer_run = (state_q == ST_LATCH) || (state_q == ST_CLK_HIGH) ||
                     (state_q == ST_CLK_LOW);

  pad_bit_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_bit_timer (
    .clk        (clk),
    .reset      (reset),
    .run_i      (timer_run),
    .phase_end_o(phase_end),
    .bit_end_o  (bit_end),
    .bit_idx_o  (bit_idx)
  );

  assign poll_d = (poll_q == POLL_LAST) ? '0 : poll_q + TW'(1);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    btn_d   = btn_q;
    valid_d = 1'b0;
    unique case (state_q)
      // Timer at zero is the cycle after it wrapped past POLL_CYCLES-1.
      ST_IDLE: begin
        if (poll_q == '0) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (bit_end) begin
          shift_d = {~pad_data, shift_q[NUM_BUTTONS-1:1]};
          state_d = ST_CLK_HIGH;
        end
      end
      ST_CLK_HIGH: begin
        if (phase_end) begin
          state_d = ST_CLK_LOW;
        end
      end
      ST_CLK_LOW: begin
        if (bit_end) begin
          shift_d = {~pad_data, shift_q[NUM_BUTTONS-1:1]};
          state_d = (bit_idx == 3'd7) ? ST_DONE : ST_CLK_HIGH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Load on entry so the new levels and valid are visible during DONE.
    if (state_d == ST_DONE) begin
      btn_d   = filter_dirs(shift_d);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      poll_q  <= '0;
      shift_q <= '0;
      btn_q   <= '0;
      valid_q <= 1'b0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      shift_q <= shift_d;
      btn_q   <= btn_d;
      valid_q <= valid_d;
      latch_q <= (state_d == ST_LATCH);
      pclk_q  <= (state_d == ST_CLK_HIGH);
    end
  end

  assign pad_latch = latch_q;
  assign pad_clk   = pclk_q;
  assign valid     = valid_q;
  assign A         = btn_q[BTN_A];
  assign B         = btn_q[BTN_B];
  assign select    = btn_q[BTN_SELECT];
  assign start     = btn_q[BTN_START];
  assign up        = btn_q[BTN_UP];
  assign down      = btn_q[BTN_DOWN];
  assign left      = btn_q[BTN_LEFT];
  assign right     = btn_q[BTN_RIGHT];

endmodule

// File: tb/tb_nes_gamepad_reader.sv
// Randomized bench for nes_gamepad_reader: a 4021-style pad model feeds the DUT
// and a frame-level timing model predicts every output on every cycle.
module tb_nes_gamepad_reader;

  localparam int H      = 2;
  localparam int P      = 64;
  localparam int DONE_M = 16 * H;
  localparam int SWAP_M = 40;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic pad_data;
  logic pad_latch, pad_clk, valid;
  logic btn_a, btn_b, btn_select, btn_start, btn_up, btn_down, btn_left, btn_right;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frame_no = 0;

  logic [7:0] pad_pressed = 8'h00;
  logic       pad_conn    = 1'b1;
  logic [7:0] pad_sr      = 8'hFF;
  logic       pclk_prev   = 1'b0;
  logic [7:0] exp_btn     = 8'h00;
  logic [7:0] frame_exp   = 8'h00;
  logic [8:0] sched_q[$];

  always #5 clk = ~clk;

  nes_gamepad_reader #(
    .HALF_PERIOD(H),
    .POLL_CYCLES(P)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .A        (btn_a),
    .B        (btn_b),
    .select   (btn_select),
    .start    (btn_start),
    .up       (btn_up),
    .down     (btn_down),
    .left     (btn_left),
    .right    (btn_right),
    .valid    (valid)
  );

  // Pad: parallel load while latched, shift toward data pin on pad_clk rise.
  always @(posedge clk) begin
    pclk_prev <= pad_clk;
    if (pad_latch) begin
      pad_sr <= ~pad_pressed;
    end else if (pad_clk && !pclk_prev) begin
      pad_sr <= {1'b1, pad_sr[7:1]};
    end
  end

  assign pad_data = pad_conn ? pad_sr[0] : 1'b1;

  function automatic logic [7:0] expect_buttons(input logic conn, input logic [7:0] pressed);
    logic [7:0] b;
    b = conn ? pressed : 8'h00;
    if (b[4] && b[5]) begin
      b[4] = 1'b0;
      b[5] = 1'b0;
    end
    if (b[6] && b[7]) begin
      b[6] = 1'b0;
      b[7] = 1'b0;
    end
    return b;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input logic e_latch, input logic e_pclk, input logic e_valid,
                           input logic [7:0] e_btn);
    logic [7:0] got_btn;
    got_btn = {btn_right, btn_left, btn_down, btn_up, btn_start, btn_select, btn_b, btn_a};
    check_eq("pad_latch", 32'(pad_latch), 32'(e_latch));
    check_eq("pad_clk", 32'(pad_clk), 32'(e_pclk));
    check_eq("valid", 32'(valid), 32'(e_valid));
    check_eq("buttons", 32'(got_btn), 32'(e_btn));
  endtask

  task automatic reset_pulse(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exp_btn = 8'h00;
      check_all(1'b0, 1'b0, 1'b0, 8'h00);
    end
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic run_cycles(input int n);
    int         m;
    logic       e_pclk;
    logic [8:0] s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      m = cyc % P;
      if (m == 0) begin
        frame_exp = expect_buttons(pad_conn, pad_pressed);
      end
      if (m == DONE_M) begin
        exp_btn = frame_exp;
        frame_no++;
        $display("frame %0d: conn=%0d pressed=%02h expect=%02h", frame_no, pad_conn,
                 pad_pressed, frame_exp);
      end
      e_pclk = (m >= 2 * H) && (m < DONE_M) && (((m - 2 * H) % (2 * H)) < H);
      check_all(m < 2 * H, e_pclk, m == DONE_M, exp_btn);
      if (m == SWAP_M && sched_q.size() > 0) begin
        s           = sched_q.pop_front();
        pad_conn    = !s[8];
        pad_pressed = s[7:0];
      end
      cyc++;
    end
  endtask

  initial begin
    pad_conn    = 1'b1;
    pad_pressed = 8'h01;
    reset_pulse(3);

    sched_q.push_back({1'b0, 8'h70});
    sched_q.push_back({1'b0, 8'h88});
    sched_q.push_back({1'b0, 8'($urandom)});
    sched_q.push_back({1'b1, 8'($urandom)});
    sched_q.push_back({1'b1, 8'($urandom)});
    sched_q.push_back({1'b0, 8'hC0});
    sched_q.push_back({1'b0, 8'h3F});
    sched_q.push_back({1'b0, 8'($urandom)});
    run_cycles(P * 8);

    run_cycles(11);
    reset_pulse(2);

    for (int i = 0; i < 4; i++) begin
      sched_q.push_back({1'b0, 8'($urandom)});
    end
    run_cycles(P * 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
